// File: rtl/priority_req_sequencer_pkg.sv
// Shared types and constants for the priority request sequencer.
// The state encoding is one-hot and matches the existing FSM snippets.
package pri_seq_pkg;

   typedef enum logic [2:0] {
      READY = 3'b001,
      SET   = 3'b010,
      GO    = 3'b100
   } states_t;

   localparam int CODE_NONE = 0;

endpackage

// File: rtl/priority_encode_comb.sv
// Combinational priority encoder: highest set bit of vec wins.
// It returns the bit index + 1 and the one-hot of the winner, or 0/0 when vec is empty.
module priority_encode_comb #(
   parameter int N      = 4,
   parameter int CODE_W = 8
) (
   input  logic [N-1:0]      vec,
   output logic [CODE_W-1:0] code,
   output logic [N-1:0]      onehot
);

   always_comb begin
      code   = '0;
      onehot = '0;
      // Ascending scan: the last hit is the highest index, so it takes priority.
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            code      = CODE_W'(i + 1);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_req_sequencer.sv
// Sticky request capture with a READY/SET/GO handshake that issues one encoded
// request code per grant, plus a saturating counter of requests lost to already-pending bits.
module priority_req_sequencer
   import pri_seq_pkg::*;
#(
   parameter int N      = 4,
   parameter int CODE_W = 8,
   parameter int DROP_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CODE_W-1:0] out_code,
   output logic [N-1:0]      pending,
   output logic              busy,
   output logic [DROP_W-1:0] drop_count
);

   logic [2:0]        state_p0;
   logic [2:0]        state_d;
   logic [N-1:0]      sel_p0;
   logic [CODE_W-1:0] code_p0;
   logic [N-1:0]      clr_mask;
   logic [N-1:0]      drop_bits;
   logic [N-1:0]      enc_onehot;
   logic [CODE_W-1:0] enc_code;

   function automatic logic [4:0] popcount(input logic [N-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [4:0]        b);
      logic [DROP_W+4:0] s;
      s = (DROP_W+5)'(a) + (DROP_W+5)'(b);
      if (s > (DROP_W+5)'({DROP_W{1'b1}})) begin
         return {DROP_W{1'b1}};
      end
      return s[DROP_W-1:0];
   endfunction

   priority_encode_comb #(
      .N      (N),
      .CODE_W (CODE_W)
   ) u_enc (
      .vec    (pending),
      .code   (enc_code),
      .onehot (enc_onehot)
   );

   // A request landing on the bit being retired is not a drop: it re-arms the bit.
   always_comb begin
      clr_mask  = (state_p0 == GO) ? sel_p0 : '0;
      drop_bits = req & pending & ~clr_mask;
   end

   always_comb begin
      state_d = READY;
      case (state_p0)
         READY:   state_d = (|pending) ? SET : READY;
         SET:     state_d = out_ready ? GO : SET;
         GO:      state_d = READY;
         default: state_d = READY;
      endcase
   end

   // Stage p0: control state, sticky pending bits and drop counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_p0   <= READY;
         pending    <= '0;
         drop_count <= '0;
      end else begin
         state_p0   <= state_d;
         pending    <= (pending & ~clr_mask) | req;
         drop_count <= sat_add(drop_count, popcount(drop_bits));
      end
   end

   // Selection is captured once on leaving READY and frozen until retired.
   always_ff @(posedge clock) begin
      if ((state_p0 == READY) && (|pending)) begin
         sel_p0  <= enc_onehot;
         code_p0 <= enc_code;
      end
   end

   always_comb begin
      out_valid = (state_p0 == SET);
      busy      = (state_p0 != READY);
      out_code  = out_valid ? code_p0 : CODE_W'(CODE_NONE);
   end

endmodule

// File: tb/tb_priority_req_sequencer.sv
// Directed bench for priority_req_sequencer: expected grant codes are queued by the
// stimulus and consumed by a monitor at each accepted handshake.
module tb_priority_req_sequencer;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_code;
   logic [3:0] pending;
   logic       busy;
   logic [7:0] drop_count;

   int         checks;
   int         errors;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic [7:0] drop_before;

   priority_req_sequencer #(
      .N      (4),
      .CODE_W (8),
      .DROP_W (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_code   (out_code),
      .pending    (pending),
      .busy       (busy),
      .drop_count (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || (pending != 4'b0)) && n < 60) begin
         tick();
         n++;
      end
      chk({name, "_idle_timeout"}, (n < 60) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Monitor: idle code must be 0, each accepted code must match the queue head.
   always @(negedge clock) begin
      if (!reset) begin
         if (!out_valid) begin
            checks++;
            if (out_code != 8'd0) begin
               errors++;
               $display("FAIL idle_code: got %0d expected 0 at %0t", out_code, $time);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_grant: got code %0d expected none at %0t", out_code, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               if (out_code != mon_exp) begin
                  errors++;
                  $display("FAIL grant_code: got %0d expected %0d at %0t", out_code, mon_exp, $time);
               end
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      req       = 4'hF;
      out_ready = 1'b0;

      // 1: reset with requests asserted
      tick();
      tick();
      reset = 1'b0;
      req   = 4'h0;
      tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_code", int'(out_code), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_drop", int'(drop_count), 0);
      chk("rst_busy", int'(busy), 0);

      // 2: two requests, consumer always ready
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd1);
      out_ready = 1'b1;
      req = 4'b0011;
      tick();
      req = 4'b0000;
      chk("t2_pending_set", int'(pending), 3);
      chk("t2_valid_lat1", int'(out_valid), 0);
      tick();
      chk("t2_valid_a", int'(out_valid), 1);
      chk("t2_code_a", int'(out_code), 2);
      tick();
      chk("t2_go_valid", int'(out_valid), 0);
      chk("t2_go_busy", int'(busy), 1);
      tick();
      chk("t2_ready_pending", int'(pending), 1);
      chk("t2_ready_busy", int'(busy), 0);
      tick();
      chk("t2_valid_b", int'(out_valid), 1);
      chk("t2_code_b", int'(out_code), 1);
      tick();
      chk("t2_valid_b_off", int'(out_valid), 0);
      tick();
      chk("t2_end_pending", int'(pending), 0);
      chk("t2_end_busy", int'(busy), 0);

      // 3: stalled consumer, higher-priority request arrives during SET
      out_ready = 1'b0;
      req = 4'b0011;
      tick();
      req = 4'b0000;
      tick();
      for (int i = 0; i < 5; i++) begin
         req = (i == 1) ? 4'b1000 : 4'b0000;
         tick();
         chk("t3_hold_valid", int'(out_valid), 1);
         chk("t3_hold_code", int'(out_code), 2);
      end
      req = 4'b0000;
      chk("t3_pending", int'(pending), 11);
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd4);
      exp_q.push_back(8'd1);
      out_ready = 1'b1;
      wait_idle("t3");

      // 4: held request counts drops, then saturates
      out_ready = 1'b0;
      req = 4'b0100;
      for (int i = 0; i < 6; i++) tick();
      chk("t4_pending", int'(pending), 4);
      chk("t4_drop5", int'(drop_count), 5);
      for (int i = 0; i < 250; i++) tick();
      chk("t4_drop_sat", int'(drop_count), 255);
      for (int i = 0; i < 5; i++) tick();
      chk("t4_drop_hold", int'(drop_count), 255);
      req = 4'b0000;
      exp_q.push_back(8'd3);
      out_ready = 1'b1;
      wait_idle("t4");
      chk("t4_drop_after", int'(drop_count), 255);
      do_reset();
      chk("t4_drop_reset", int'(drop_count), 0);

      // 5: request on the bit being retired in GO
      drop_before = drop_count;
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd2);
      out_ready = 1'b1;
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      chk("t5_set_code", int'(out_code), 2);
      tick();
      chk("t5_in_go", int'(busy && !out_valid), 1);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      chk("t5_pending_kept", int'(pending), 2);
      wait_idle("t5");
      chk("t5_drop_same", int'(drop_count), int'(drop_before));

      // 6: reset during SET
      out_ready = 1'b0;
      req = 4'b0101;
      tick();
      req = 4'b0000;
      tick();
      chk("t6_valid", int'(out_valid), 1);
      chk("t6_code", int'(out_code), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_pending", int'(pending), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6_no_grant", int'(out_valid), 0);
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
